l2_hdr_sequencer: RTL and testbench
===================================

L2_HDR_SEQUENCER -- requirements
Module: l2_hdr_sequencer

Interface
REQ-001 SHALL have parameter L2_HEADER_MAX_BYTES, default 18, header capture depth in bytes.
REQ-002 SHALL have parameter RESOLVE_TIMEOUT, default 16, maximum cycles to wait for the resolver.
REQ-003 SHALL have ports: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-004 SHALL have ports: in_valid in 1, in_data in 8, in_sof in 1, in_eof in 1, in_ready out 1 (byte stream; a byte transfers when in_valid && in_ready).
REQ-005 SHALL have ports: hdr_fields_valid out 1, hdr_ethertype_raw out 16, hdr_bytes out L2_HEADER_MAX_BYTES*8 (drive to resolver).
REQ-006 SHALL have ports: res_vlan_valid in 1, res_vlan_present in 1, res_vlan_id in 12, res_ethertype in 16, res_l2_len in 5 (from resolver).
REQ-007 SHALL have ports: desc_valid out 1, desc_ready in 1, desc_vlan_present out 1, desc_vlan_id out 12, desc_ethertype out 16, desc_l2_len out 5, desc_runt out 1, desc_err out 1.
REQ-008 SHALL have ports: stat_frames out 16, stat_runts out 16, err_timeout out 1 (single-cycle pulse).

Function
REQ-009 SHALL implement states IDLE, CAPTURE, RESOLVE, DELIVER, DRAIN.
REQ-010 in_ready SHALL be 1 in IDLE, CAPTURE and DRAIN, and 0 in RESOLVE and DELIVER.
REQ-011 Accepted byte k of a frame SHALL be stored at hdr_bytes[8k+7:8k]; bytes never received in the current frame SHALL read 0 (buffer cleared at each accepted in_sof).
REQ-012 hdr_ethertype_raw SHALL equal {byte12, byte13}; byte12 is the high byte.
REQ-013 IDLE: an accepted byte with in_sof stores byte 0, sets count=1 and enters CAPTURE; accepted bytes without in_sof are discarded.
REQ-014 CAPTURE: each accepted byte stores at index count and increments count; an accepted in_sof restarts capture with that byte as byte 0.
REQ-015 When count reaches L2_HEADER_MAX_BYTES, or in_eof is accepted, the block SHALL record eof_seen (if in_eof) and evaluate the frame.
REQ-016 The frame SHALL be a runt if total bytes < 14, or if the ethertype is 0x8100 and total bytes < 18.
REQ-017 A runt SHALL bypass the resolver and go to DELIVER with desc_runt=1; all other descriptor fields are 0.
REQ-018 A non-runt SHALL go to RESOLVE; hdr_fields_valid SHALL be 1 only in RESOLVE.
REQ-019 RESOLVE: the first cycle res_vlan_valid=1 SHALL latch res_* into desc_* and enter DELIVER; desc_valid SHALL assert in the next cycle.
REQ-020 If res_vlan_valid is not seen within RESOLVE_TIMEOUT cycles of entering RESOLVE, the block SHALL pulse err_timeout and enter DELIVER with desc_err=1 and other fields 0.
REQ-021 DELIVER: desc_valid=1; desc_* SHALL be held stable until desc_ready=1.
REQ-022 On the desc handshake, the block SHALL go to IDLE if eof_seen, else to DRAIN.
REQ-023 DRAIN: accepted bytes SHALL be discarded; an accepted in_eof goes to IDLE; an accepted in_sof starts a new capture (count=1, CAPTURE).
REQ-024 When a byte carries both in_sof and in_eof, it SHALL be treated as a 1-byte frame: runt.
REQ-025 stat_frames SHALL increment on every desc handshake; stat_runts SHALL increment on handshakes with desc_runt=1; both counters wrap modulo 2^16.
REQ-026 hdr_fields_valid SHALL be 0 for at least one cycle between successive RESOLVE entries, so the resolver re-arms.

Reset
REQ-027 While rst_n=0, the block SHALL be in IDLE with count=0, eof_seen=0, hdr_bytes=0, and all desc_* = 0.
REQ-028 While rst_n=0, desc_valid, hdr_fields_valid, err_timeout = 0, stat_* = 0, and in_ready = 0.
REQ-029 in_ready SHALL first assert in the cycle after rst_n deasserts.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no descriptor emitted.

Verification
REQ-031 Untagged 64-byte frame with bytes 12-13 = 0x0800, and a resolver model returning ethertype 0x0800, l2_len 14 -> one descriptor: present=0, ethertype 0x0800, runt=0; DRAIN consumes the rest; stat_frames=1.
REQ-032 Tagged frame with bytes 12-13 = 0x8100, TCI 0x2064, bytes 16-17 = 0x86DD -> descriptor: present=1, id 0x064, ethertype 0x86DD, l2_len 18.
REQ-033 10-byte frame -> runt=1, stat_runts=1, hdr_fields_valid never asserts; a 16-byte frame with 0x8100 -> runt=1.
REQ-034 Resolver held silent -> err_timeout pulses exactly 16 cycles after RESOLVE entry; descriptor has desc_err=1.
REQ-035 desc_ready held 0 for 20 cycles -> desc_* stable throughout and in_ready=0; in_sof during DRAIN -> new frame is captured correctly.
REQ-036 rst_n asserted at byte 7 of a frame -> all outputs at reset values; the next frame is parsed normally.

Source files
------------

// File: rtl/l2_hdr_sequencer.sv
// L2 header sequencer: captures the first bytes of each frame, hands them to an
// external resolver, and emits one descriptor per frame with backpressure.
module l2_hdr_sequencer #(
    parameter int L2_HEADER_MAX_BYTES = 18,
    parameter int RESOLVE_TIMEOUT     = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [7:0]                       in_data,
    input  logic                             in_sof,
    input  logic                             in_eof,
    output logic                             in_ready,
    output logic                             hdr_fields_valid,
    output logic [15:0]                      hdr_ethertype_raw,
    output logic [L2_HEADER_MAX_BYTES*8-1:0] hdr_bytes,
    input  logic                             res_vlan_valid,
    input  logic                             res_vlan_present,
    input  logic [11:0]                      res_vlan_id,
    input  logic [15:0]                      res_ethertype,
    input  logic [4:0]                       res_l2_len,
    output logic                             desc_valid,
    input  logic                             desc_ready,
    output logic                             desc_vlan_present,
    output logic [11:0]                      desc_vlan_id,
    output logic [15:0]                      desc_ethertype,
    output logic [4:0]                       desc_l2_len,
    output logic                             desc_runt,
    output logic                             desc_err,
    output logic [15:0]                      stat_frames,
    output logic [15:0]                      stat_runts,
    output logic                             err_timeout,
    output logic [2:0]                       dbg_state
);

    localparam int HW = L2_HEADER_MAX_BYTES * 8;
    localparam int CW = $clog2(L2_HEADER_MAX_BYTES + 1);
    localparam int TW = $clog2(RESOLVE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        RESOLVE = 3'd2,
        DELIVER = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [TW-1:0] timer;
    logic          eof_seen;
    logic          ready_en;

    logic          xfer;
    logic          start;
    logic          capture_byte;
    logic [CW-1:0] wr_idx;
    logic [CW-1:0] cnt_nxt;
    logic [HW-1:0] hdr_nxt;
    logic [15:0]   etype_nxt;
    logic          frame_done;
    logic          runt_nxt;

    // Handshakes: a byte moves when in_valid && in_ready on a rising edge, and a
    // descriptor moves when desc_valid && desc_ready; desc_* hold while unaccepted.
    assign in_ready          = ready_en && (state == IDLE || state == CAPTURE || state == DRAIN);
    assign hdr_fields_valid  = (state == RESOLVE);
    assign desc_valid        = (state == DELIVER);
    assign hdr_ethertype_raw = {hdr_bytes[96 +: 8], hdr_bytes[104 +: 8]};
    assign dbg_state         = state;

    always_comb begin
        xfer         = in_valid && in_ready;
        start        = xfer && in_sof;
        capture_byte = start || (xfer && state == CAPTURE);
        wr_idx       = start ? '0 : count;
        cnt_nxt      = wr_idx + CW'(1);
        hdr_nxt      = '0;
        // A start-of-frame byte clears the buffer so unreceived bytes read as zero.
        for (int i = 0; i < L2_HEADER_MAX_BYTES; i++) begin
            if (wr_idx == CW'(i))
                hdr_nxt[8*i +: 8] = in_data;
            else
                hdr_nxt[8*i +: 8] = start ? 8'h00 : hdr_bytes[8*i +: 8];
        end
        etype_nxt  = {hdr_nxt[96 +: 8], hdr_nxt[104 +: 8]};
        frame_done = capture_byte && (in_eof || cnt_nxt == CW'(L2_HEADER_MAX_BYTES));
        runt_nxt   = (cnt_nxt < CW'(14)) || (etype_nxt == 16'h8100 && cnt_nxt < CW'(18));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            count             <= '0;
            timer             <= '0;
            eof_seen          <= 1'b0;
            ready_en          <= 1'b0;
            hdr_bytes         <= '0;
            desc_vlan_present <= 1'b0;
            desc_vlan_id      <= '0;
            desc_ethertype    <= '0;
            desc_l2_len       <= '0;
            desc_runt         <= 1'b0;
            desc_err          <= 1'b0;
            stat_frames       <= '0;
            stat_runts        <= '0;
            err_timeout       <= 1'b0;
        end else begin
            ready_en    <= 1'b1;
            err_timeout <= 1'b0;
            case (state)
                IDLE, CAPTURE, DRAIN: begin
                    if (capture_byte) begin
                        hdr_bytes <= hdr_nxt;
                        count     <= cnt_nxt;
                        if (frame_done) begin
                            eof_seen <= in_eof;
                            if (runt_nxt) begin
                                state             <= DELIVER;
                                desc_runt         <= 1'b1;
                                desc_err          <= 1'b0;
                                desc_vlan_present <= 1'b0;
                                desc_vlan_id      <= '0;
                                desc_ethertype    <= '0;
                                desc_l2_len       <= '0;
                            end else begin
                                state <= RESOLVE;
                                timer <= '0;
                            end
                        end else begin
                            state    <= CAPTURE;
                            eof_seen <= 1'b0;
                        end
                    end else if (state == DRAIN && xfer && in_eof) begin
                        state    <= IDLE;
                        eof_seen <= 1'b0;
                    end
                end
                RESOLVE: begin
                    if (res_vlan_valid) begin
                        state             <= DELIVER;
                        desc_vlan_present <= res_vlan_present;
                        desc_vlan_id      <= res_vlan_id;
                        desc_ethertype    <= res_ethertype;
                        desc_l2_len       <= res_l2_len;
                        desc_runt         <= 1'b0;
                        desc_err          <= 1'b0;
                    end else if (timer == TW'(RESOLVE_TIMEOUT - 1)) begin
                        // Last permitted cycle passed without an answer from the resolver.
                        state             <= DELIVER;
                        err_timeout       <= 1'b1;
                        desc_err          <= 1'b1;
                        desc_runt         <= 1'b0;
                        desc_vlan_present <= 1'b0;
                        desc_vlan_id      <= '0;
                        desc_ethertype    <= '0;
                        desc_l2_len       <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DELIVER: begin
                    if (desc_ready) begin
                        stat_frames <= stat_frames + 16'd1;
                        if (desc_runt)
                            stat_runts <= stat_runts + 16'd1;
                        state    <= eof_seen ? IDLE : DRAIN;
                        eof_seen <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_hdr_sequencer.sv
// Directed bench for l2_hdr_sequencer: drives byte frames, plays the resolver
// by hand and checks descriptors, stats and reset behaviour with assertions.
module tb_l2_hdr_sequencer;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RESOLVE = 3'd2;
    localparam logic [2:0] S_DELIVER = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_sof, in_eof, in_ready;
    logic [7:0]   in_data;
    logic         hdr_fields_valid;
    logic [15:0]  hdr_ethertype_raw;
    logic [143:0] hdr_bytes;
    logic         res_vlan_valid, res_vlan_present;
    logic [11:0]  res_vlan_id;
    logic [15:0]  res_ethertype;
    logic [4:0]   res_l2_len;
    logic         desc_valid, desc_ready, desc_vlan_present, desc_runt, desc_err;
    logic [11:0]  desc_vlan_id;
    logic [15:0]  desc_ethertype;
    logic [4:0]   desc_l2_len;
    logic [15:0]  stat_frames, stat_runts;
    logic         err_timeout;
    logic [2:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    int hfv_cycles = 0;
    logic [7:0] fb [0:63];

    l2_hdr_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
        .in_ready(in_ready),
        .hdr_fields_valid(hdr_fields_valid), .hdr_ethertype_raw(hdr_ethertype_raw),
        .hdr_bytes(hdr_bytes),
        .res_vlan_valid(res_vlan_valid), .res_vlan_present(res_vlan_present),
        .res_vlan_id(res_vlan_id), .res_ethertype(res_ethertype), .res_l2_len(res_l2_len),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_vlan_present(desc_vlan_present), .desc_vlan_id(desc_vlan_id),
        .desc_ethertype(desc_ethertype), .desc_l2_len(desc_l2_len),
        .desc_runt(desc_runt), .desc_err(desc_err),
        .stat_frames(stat_frames), .stat_runts(stat_runts),
        .err_timeout(err_timeout), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (hdr_fields_valid === 1'b1) hfv_cycles <= hfv_cycles + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build(input logic [15:0] et, input logic [15:0] w14,
                         input logic [15:0] w16, input logic [7:0] seed);
        for (int i = 0; i < 64; i++) fb[i] = seed + 8'(i);
        fb[12] = et[15:8];  fb[13] = et[7:0];
        fb[14] = w14[15:8]; fb[15] = w14[7:0];
        fb[16] = w16[15:8]; fb[17] = w16[7:0];
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        int w;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_sof = s; in_eof = e;
        w = 0;
        while (in_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) check("in_ready_wait", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
    endtask

    task automatic send_range(input int first, input int last, input logic sof_first,
                              input logic eof_last);
        for (int i = first; i <= last; i++)
            send_byte(fb[i], sof_first && (i == first), eof_last && (i == last));
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the resolver answer.
    task automatic resolve(input logic p, input logic [11:0] id, input logic [15:0] et,
                           input logic [4:0] len);
        res_vlan_valid = 1'b1; res_vlan_present = p; res_vlan_id = id;
        res_ethertype = et; res_l2_len = len;
        @(posedge clk);
        @(negedge clk);
        res_vlan_valid = 1'b0;
    endtask

    task automatic handshake();
        desc_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        desc_ready = 1'b0;
    endtask

    initial begin
        int h0, first_k, pulses, bad;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_sof = 1'b0; in_eof = 1'b0;
        res_vlan_valid = 1'b0; res_vlan_present = 1'b0; res_vlan_id = '0;
        res_ethertype = '0; res_l2_len = '0; desc_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_desc_valid", desc_valid, 0);
        check("rst_hfv", hdr_fields_valid, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_stat_frames", stat_frames, 0);
        check("rst_stat_runts", stat_runts, 0);
        check("rst_hdr_bytes", |hdr_bytes, 0);
        check("rst_state", dbg_state, S_IDLE);
        check("rst_desc_fields", {desc_vlan_present, desc_vlan_id, desc_ethertype, desc_l2_len, desc_runt, desc_err}, 0);
        rst_n = 1'b1;
        #1 check("in_ready_release_cycle", in_ready, 0);
        @(negedge clk);
        check("in_ready_after_release", in_ready, 1);

        // Untagged 64-byte frame, remainder drained
        build(16'h0800, 16'h1122, 16'h3344, 8'h10);
        send_range(0, 17, 1'b1, 1'b0);
        idle_in();
        check("u_hfv", hdr_fields_valid, 1);
        check("u_in_ready", in_ready, 0);
        check("u_etype_raw", hdr_ethertype_raw, 16'h0800);
        check("u_state", dbg_state, S_RESOLVE);
        check("u_byte0", hdr_bytes[7:0], 8'h10);
        check("u_byte17", hdr_bytes[143:136], 8'h44);
        resolve(1'b0, 12'h000, 16'h0800, 5'd14);
        check("u_desc_valid", desc_valid, 1);
        check("u_hfv_off", hdr_fields_valid, 0);
        check("u_present", desc_vlan_present, 0);
        check("u_etype", desc_ethertype, 16'h0800);
        check("u_len", desc_l2_len, 14);
        check("u_runt_err", {desc_runt, desc_err}, 0);
        handshake();
        check("u_stat_frames", stat_frames, 1);
        check("u_stat_runts", stat_runts, 0);
        check("u_drain_state", dbg_state, S_DRAIN);
        check("u_drain_ready", in_ready, 1);
        send_range(18, 63, 1'b0, 1'b1);
        idle_in();
        check("u_after_drain_state", dbg_state, S_IDLE);
        check("u_after_drain_dv", desc_valid, 0);
        check("u_drain_no_write", hdr_bytes[7:0], 8'h10);

        // Tagged frame of exactly 18 bytes
        build(16'h8100, 16'h2064, 16'h86DD, 8'h40);
        send_range(0, 17, 1'b1, 1'b1);
        idle_in();
        check("t_hfv", hdr_fields_valid, 1);
        check("t_etype_raw", hdr_ethertype_raw, 16'h8100);
        resolve(1'b1, 12'h064, 16'h86DD, 5'd18);
        check("t_present", desc_vlan_present, 1);
        check("t_id", desc_vlan_id, 12'h064);
        check("t_etype", desc_ethertype, 16'h86DD);
        check("t_len", desc_l2_len, 18);
        handshake();
        check("t_state_idle", dbg_state, S_IDLE);
        check("t_stat_frames", stat_frames, 2);

        // Runts: 10 bytes, 16-byte tagged, single sof+eof byte
        h0 = hfv_cycles;
        build(16'h0800, 16'h0000, 16'h0000, 8'h70);
        send_range(0, 9, 1'b1, 1'b1);
        idle_in();
        check("r10_desc_valid", desc_valid, 1);
        check("r10_runt", desc_runt, 1);
        check("r10_fields_zero", {desc_vlan_present, desc_vlan_id, desc_ethertype, desc_l2_len, desc_err}, 0);
        check("r10_byte9", hdr_bytes[79:72], 8'h79);
        check("r10_unreceived_zero", hdr_bytes[143:80], 0);
        handshake();
        check("r10_stat_runts", stat_runts, 1);
        check("r10_stat_frames", stat_frames, 3);
        build(16'h8100, 16'h0005, 16'h0800, 8'hA0);
        send_range(0, 15, 1'b1, 1'b1);
        idle_in();
        check("r16_runt", desc_runt, 1);
        check("r16_hfv", hdr_fields_valid, 0);
        check("r16_present", desc_vlan_present, 0);
        handshake();
        check("r16_stat_runts", stat_runts, 2);
        send_byte(8'h5A, 1'b1, 1'b1);
        idle_in();
        check("r1_runt", desc_runt, 1);
        check("r1_byte0", hdr_bytes[7:0], 8'h5A);
        check("r1_rest_zero", |hdr_bytes[143:8], 0);
        handshake();
        check("r1_stat_runts", stat_runts, 3);
        check("r1_stat_frames", stat_frames, 5);
        check("r1_state_idle", dbg_state, S_IDLE);
        check("runts_no_hfv", hfv_cycles, h0);

        // Silent resolver: timeout pulse 16 cycles after RESOLVE entry
        build(16'h0800, 16'h0000, 16'h0000, 8'h30);
        send_range(0, 17, 1'b1, 1'b1);
        first_k = -1; pulses = 0;
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
            if (err_timeout === 1'b1) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
        check("to_pulse_cycle", first_k, 16);
        check("to_pulse_count", pulses, 1);
        check("to_desc_valid", desc_valid, 1);
        check("to_desc_err", desc_err, 1);
        check("to_fields_zero", {desc_vlan_present, desc_vlan_id, desc_ethertype, desc_l2_len, desc_runt}, 0);
        handshake();
        check("to_stat_frames", stat_frames, 6);

        // Descriptor backpressure, then sof during DRAIN
        build(16'h0800, 16'h0000, 16'h0000, 8'hC0);
        send_range(0, 17, 1'b1, 1'b0);
        idle_in();
        resolve(1'b0, 12'h000, 16'h0800, 5'd14);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1; in_sof = 1'b1; in_data = 8'hEE;
            @(negedge clk);
            if (desc_valid !== 1'b1 || in_ready !== 1'b0 || desc_ethertype !== 16'h0800 ||
                desc_l2_len !== 5'd14 || desc_vlan_present !== 1'b0 || dbg_state !== S_DELIVER)
                bad++;
        end
        in_valid = 1'b0; in_sof = 1'b0;
        check("bp_stable", bad, 0);
        check("bp_no_capture", hdr_bytes[7:0], 8'hC0);
        handshake();
        check("bp_drain", dbg_state, S_DRAIN);
        send_byte(fb[18], 1'b0, 1'b0);
        build(16'h88B5, 16'h0000, 16'h0000, 8'h01);
        send_range(0, 13, 1'b1, 1'b1);
        idle_in();
        check("ds_hfv", hdr_fields_valid, 1);
        check("ds_etype_raw", hdr_ethertype_raw, 16'h88B5);
        check("ds_byte0", hdr_bytes[7:0], 8'h01);
        check("ds_cleared", hdr_bytes[143:112], 0);
        resolve(1'b0, 12'h000, 16'h88B5, 5'd14);
        check("ds_etype", desc_ethertype, 16'h88B5);
        handshake();
        check("ds_state_idle", dbg_state, S_IDLE);
        check("ds_stat_frames", stat_frames, 8);

        // Reset in the middle of a frame
        build(16'h0800, 16'h0000, 16'h0000, 8'h90);
        send_range(0, 6, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        #1;
        check("mr_in_ready", in_ready, 0);
        check("mr_hdr_bytes", |hdr_bytes, 0);
        check("mr_state", dbg_state, S_IDLE);
        check("mr_stats", {stat_frames, stat_runts}, 0);
        check("mr_desc", {desc_valid, desc_ethertype, desc_l2_len, hdr_fields_valid, err_timeout}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        build(16'h8100, 16'h0ABC, 16'h0800, 8'h20);
        send_range(0, 17, 1'b1, 1'b1);
        idle_in();
        check("mr_next_hfv", hdr_fields_valid, 1);
        resolve(1'b1, 12'hABC, 16'h0800, 5'd18);
        check("mr_next_id", desc_vlan_id, 12'hABC);
        check("mr_next_present", desc_vlan_present, 1);
        handshake();
        check("mr_next_stat", stat_frames, 1);
        check("mr_next_idle", dbg_state, S_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
